// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: owns the accumulator and sequences the external 12-bit ALU one command
// at a time.
//
// Commands {op, operand} arrive over a valid/ready channel. Each command drives the ALU
// with a registered op code and bus value. After the op latency, the ALU result is written
// to AC and the zero flag is registered. AC is then returned over a valid/ready response
// channel.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_op, cmd_data    op code and bus operand, sampled on handshake
//   alu_op, alu_bus     registered op code and operand presented to the ALU
//   alu_ac              accumulator value presented to the ALU (same as ac)
//   alu_result          combinational ALU result
//   ac, z_flag          accumulator and registered zero flag
//   rsp_valid/ready     response handshake
//   rsp_data, rsp_err   AC after the command; illegal-op indication
//   busy                controller not idle
module alu_exec_ctrl #(
  parameter int unsigned reg_width  = 12,
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [reg_width-1:0] cmd_data,
  output logic [2:0]           alu_op,
  output logic [reg_width-1:0] alu_bus,
  output logic [reg_width-1:0] alu_ac,
  input  logic [reg_width-1:0] alu_result,
  output logic [reg_width-1:0] ac,
  output logic                 z_flag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [reg_width-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [2:0] OpNop = 3'b000;
  localparam logic [2:0] OpSub = 3'b011;
  localparam logic [2:0] OpMul = 3'b100;
  localparam logic [2:0] OpIll = 3'b111;

  localparam int unsigned    CntW   = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  // Counter holds the number of EXEC cycles remaining after the current one.
  localparam logic [CntW-1:0] MulCnt = CntW'(MUL_CYCLES - 1);

  state_e          state;
  logic [CntW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= StIdle;
      cnt     <= '0;
      ac      <= '0;
      z_flag  <= 1'b0;
      alu_op  <= OpNop;
      alu_bus <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (cmd_valid) begin
            if (cmd_op == OpNop) begin
              rsp_err <= 1'b0;
              state   <= StResp;
            end else if (cmd_op == OpIll) begin
              rsp_err <= 1'b1;
              state   <= StResp;
            end else begin
              alu_op  <= cmd_op;
              alu_bus <= cmd_data;
              cnt     <= (cmd_op == OpMul) ? MulCnt : '0;
              state   <= StExec;
            end
          end
        end
        StExec: begin
          if (cnt == '0) begin
            ac      <= alu_result;
            // Only a Sub can raise the flag; the ALU's own zero output is ignored.
            z_flag  <= (alu_op == OpSub) && (alu_result == '0);
            alu_op  <= OpNop;
            rsp_err <= 1'b0;
            state   <= StResp;
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign cmd_ready = (state == StIdle);
  assign busy      = (state != StIdle);
  assign rsp_valid = (state == StResp);
  assign rsp_data  = ac;
  assign alu_ac    = ac;

endmodule
